// File: rtl/bist_sched_if.sv
`timescale 1ns/1ps
// System request/result and BIST engine handshake signals for the run sequencer.
// The master modport is the sequencer's view; the slave modport is the system and engine side.
interface bist_sched_if #(
  parameter int CNT_W = 3
);
  logic             go;
  logic             busy;
  logic             fin;
  logic             pass;
  logic [CNT_W-1:0] fail_cnt;
  logic             timeout;
  logic             bist_start;
  logic             bist_status;
  logic             bist_done;

  modport master (
    input  go,
    input  bist_status,
    input  bist_done,
    output busy,
    output fin,
    output pass,
    output fail_cnt,
    output timeout,
    output bist_start
  );

  modport slave (
    output go,
    output bist_status,
    output bist_done,
    input  busy,
    input  fin,
    input  pass,
    input  fail_cnt,
    input  timeout,
    input  bist_start
  );
endinterface

// File: rtl/bist_sched.sv
`timescale 1ns/1ps
// Run sequencer for the memory BIST engine: launches RUNS back-to-back runs per request,
// watchdogs each run and holds an aggregated pass / fail-count / timeout result.
module bist_sched #(
  parameter int RUNS    = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 10
) (
  input  logic         clk,
  input  logic         rst,
  bist_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, GAP, REPORT} state_t;

  localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(RUNS - 1);
  localparam logic [TO_W-1:0]  WDOG_MAX = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic             go_d;
  logic             bist_start;
  logic             busy;
  logic             fin;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [TO_W-1:0]  wdog;

  logic             go_rise;
  logic             last_run;
  logic             wdog_exp;
  logic [CNT_W-1:0] fail_upd;

  always_comb begin
    go_rise  = bus.go && !go_d;
    last_run = (run_cnt == LAST_RUN);
    wdog_exp = (wdog == WDOG_MAX);
    fail_upd = fail_cnt;
    // Saturate so an oversized failure count never wraps back to a passing value.
    if (bus.bist_status && (fail_cnt != '1)) fail_upd = fail_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      go_d       <= 1'b0;
      bist_start <= 1'b0;
      busy       <= 1'b0;
      fin        <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_cnt   <= '0;
      run_cnt    <= '0;
      wdog       <= '0;
    end else begin
      go_d       <= bus.go;
      bist_start <= 1'b0;
      fin        <= 1'b0;
      case (state)
        IDLE: begin
          if (go_rise) begin
            fail_cnt   <= '0;
            timeout    <= 1'b0;
            pass       <= 1'b0;
            run_cnt    <= '0;
            wdog       <= '0;
            bist_start <= 1'b1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 1'b1;
          // A completion on the expiry cycle still counts as a finished run.
          if (bus.bist_done) begin
            fail_cnt <= fail_upd;
            run_cnt  <= run_cnt + 1'b1;
            if (last_run) begin
              fin   <= 1'b1;
              state <= REPORT;
            end else begin
              state <= GAP;
            end
          end else if (wdog_exp) begin
            timeout <= 1'b1;
            fin     <= 1'b1;
            state   <= REPORT;
          end
        end
        GAP: begin
          // Done is a level; wait for it to fall so one completion is never counted twice.
          if (!bus.bist_done) begin
            bist_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        REPORT: begin
          pass  <= (fail_cnt == '0) && !timeout;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bist_start = bist_start;
  assign bus.busy       = busy;
  assign bus.fin        = fin;
  assign bus.pass       = pass;
  assign bus.fail_cnt   = fail_cnt;
  assign bus.timeout    = timeout;
endmodule

// File: doc/bist_sched.md
Name: bist_sched

Overview:
- Sequencer that sits directly upstream of the memory BIST engine (ports start / status / done).
- On a system request it launches the engine RUNS times back-to-back, samples the error status at each completion and guards every run with a watchdog.
- It presents one aggregated pass/fail result, a failing-run count and a timeout flag to the system.

Parameters:
RUNS, 4, number of BIST runs per request (>=1)
CNT_W, 3, width of run and fail counters; must satisfy 2^CNT_W > RUNS
TIMEOUT, 1024, max cycles allowed in WAIT per run before abort
TO_W, 10, watchdog counter width; must satisfy 2^TO_W >= TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
go  input  1  level request; a rising edge starts a sequence
bist_start  output  1  start strobe to BIST engine, one cycle per run
bist_status  input  1  engine error status, 1 = mismatch; valid only while bist_done=1
bist_done  input  1  engine completion; level, may stay high until the next start
busy  output  1  1 in every state except IDLE
fin  output  1  one-cycle pulse when a sequence ends
pass  output  1  1 = all runs done with status 0 and no timeout; held
fail_cnt  output  CNT_W  number of runs that reported status=1; held
timeout  output  1  watchdog expired in last sequence; held

Behaviour:
- Reset (rst=0, async): state=IDLE; bist_start=0, busy=0, fin=0, pass=0, fail_cnt=0, timeout=0; run counter, watchdog and go_d all 0.
- go_d is a registered copy of go. Start condition: go=1 and go_d=0 while in IDLE. A go edge in any other state is ignored and is not queued.
- States and transitions:
  - IDLE: on start condition, clear fail_cnt, timeout, pass, run counter and watchdog, then go to LAUNCH.
  - LAUNCH: bist_start=1 (Moore, exactly this one cycle). Clear watchdog. Go to WAIT.
  - WAIT: watchdog increments each cycle.
    - If bist_done=1: if bist_status=1, fail_cnt increments, saturating at all-ones. Run counter increments. If the run counter was RUNS-1, go to REPORT; otherwise go to GAP.
    - Else if watchdog = TIMEOUT-1: set timeout=1 and go to REPORT. No further runs are launched.
    - bist_done=1 has priority over watchdog expiry in the same cycle.
  - GAP: wait until bist_done=0, then go to LAUNCH. This prevents a stale level done from being counted twice.
  - REPORT: fin=1 for this one cycle. pass registered as (fail_cnt==0 && timeout==0), using the updated fail_cnt. Go to IDLE.
- Latency:
  - go rising in cycle n (state IDLE) gives bist_start=1 in cycle n+1.
  - bist_done sampled in WAIT at cycle m gives the next bist_start no earlier than m+2, if done has fallen.
  - Final done sampled in WAIT at cycle m gives fin=1 in cycle m+1.
- Held outputs (pass, fail_cnt, timeout) keep their values from REPORT until the next accepted start condition clears them.
- go held high continuously produces exactly one sequence. A new sequence needs go to return to 0 first.
- bist_done already high on entry to WAIT after LAUNCH is accepted as completion. The engine must drop done within the LAUNCH cycle; the engine already does this.
- Reset asserted mid-sequence aborts immediately to reset values. No fin pulse is produced.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, go=0 → all outputs 0, busy=0, no bist_start for 20 cycles.
- Clean sequence, RUNS=4: go 0→1; engine model returns done with status=0 after 10 cycles each run → 4 single-cycle bist_start pulses, fin pulse once, pass=1, fail_cnt=0, timeout=0, busy falls same cycle fin falls.
- Mixed errors: status=1 on runs 2 and 4 → fail_cnt=2, pass=0, timeout=0. Repeat with status=1 on all runs and CNT_W=2, RUNS=3 → fail_cnt=3, no wrap.
- Watchdog, TIMEOUT=16: engine never asserts done on run 2 → fin 16 cycles after run-2 bist_start+1, timeout=1, pass=0, exactly 2 bist_start pulses total. Also cover done=1 exactly on watchdog cycle 15 → run counted, timeout=0.
- Level done / go handling: engine holds done high 5 cycles after each completion → no double counting, next bist_start only after done falls. go toggled during busy → ignored. go held high after fin → no second sequence.
- Mid-run reset: assert rst=0 during WAIT of run 3 → outputs return to reset values asynchronously. After release plus a go edge, a full fresh sequence runs with fail_cnt counting from 0.
